// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V data-memory controller.
// Contents: controller FSM state type, wait-counter width, captured request payload.
package riscv_pkg;

  // Wide enough for WAIT_CYCLES in 0..15
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Request fields latched when an access is accepted; the word index is held separately
  // because its width depends on the RAM depth.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } dmem_req_t;

endpackage

// File: rtl/riscv_dmem_ctrl_if.sv
// Load/store-unit to data-memory bus.
// Requester side: mem_req_i, mem_we_i, mem_be_i[3:0], mem_addr_i[31:0], mem_wd_i[31:0].
// Memory side:    mem_rd_o[31:0] (read word), mem_ready_o (one-cycle completion pulse).
interface riscv_dmem_ctrl_if;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wd_i;
  logic [31:0] mem_rd_o;
  logic        mem_ready_o;

  modport master (
    output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wd_i,
    input  mem_rd_o, mem_ready_o
  );

  modport slave (
    input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wd_i,
    output mem_rd_o, mem_ready_o
  );

endinterface

// File: rtl/riscv_dmem_ram.sv
// Byte-enabled single-port data RAM.
// Ports: clk_i, rst_i (clears only the read register), i_en (access strobe),
//        i_we (1 = write), i_be[3:0] (write lane enables), i_idx (word index),
//        i_wd[31:0] (write data), o_rd[31:0] (registered read word, held between loads).
module riscv_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wd,
  output logic [31:0]                    o_rd
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd;

  // Write port: only enabled lanes are updated; array contents are never reset
  always_ff @(posedge clk_i) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wd[8*b +: 8];
      end
    end
  end

  // Read port: updates on loads only, so stores leave the last read word visible
  always_ff @(posedge clk_i) begin
    if (rst_i)                r_rd <= '0;
    else if (i_en && !i_we)   r_rd <= r_mem[i_idx];
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: accepts one load/store at a time, inserts WAIT_CYCLES wait
// states, performs the RAM access on the edge entering RESP and pulses mem_ready_o.
// Ports: clk_i, rst_i (sync, active-high), bus (riscv_dmem_ctrl_if.slave).
// Optional: define RISCV_DMEM_STATS_EN to add load_cnt_o / store_cnt_o completion counters.
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  riscv_dmem_ctrl_if.slave   bus
`ifdef RISCV_DMEM_STATS_EN
  ,
  output logic [31:0]        load_cnt_o,
  output logic [31:0]        store_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e           r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_ready;
  dmem_req_t             r_req;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_cap;
  logic                  w_acc;
  logic                  w_acc_we;
  logic [3:0]            w_acc_be;
  logic [IDX_W-1:0]      w_acc_idx;
  logic [31:0]           w_acc_wd;
  logic [31:0]           w_rd;
  logic                  w_unused_addr;

  // Address bits outside the word index are intentionally dropped (address wrap)
  assign w_unused_addr = ^{bus.mem_addr_i[31:IDX_W+2], bus.mem_addr_i[1:0]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == RESP);
    end
  end

  // Request capture; contents are don't-care outside an access
  always_ff @(posedge clk_i) begin
    if (w_cap) begin
      r_req <= '{we: bus.mem_we_i, be: bus.mem_be_i, wd: bus.mem_wd_i};
      r_idx <= bus.mem_addr_i[IDX_W+1:2];
    end
  end

  // Next-state logic; w_acc marks the edge that enters RESP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_req_i) begin
          w_cap = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end else begin
            w_state_nxt = RESP;
            w_acc       = 1'b1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_acc       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so take the live bus
  assign w_acc_we  = (r_state == IDLE) ? bus.mem_we_i               : r_req.we;
  assign w_acc_be  = (r_state == IDLE) ? bus.mem_be_i               : r_req.be;
  assign w_acc_idx = (r_state == IDLE) ? bus.mem_addr_i[IDX_W+1:2]  : r_idx;
  assign w_acc_wd  = (r_state == IDLE) ? bus.mem_wd_i               : r_req.wd;

  // Reset suppresses an in-flight access
  riscv_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_acc & ~rst_i),
    .i_we  (w_acc_we),
    .i_be  (w_acc_be),
    .i_idx (w_acc_idx),
    .i_wd  (w_acc_wd),
    .o_rd  (w_rd)
  );

  assign bus.mem_rd_o    = w_rd;
  assign bus.mem_ready_o = r_ready;

`ifdef RISCV_DMEM_STATS_EN
  logic [31:0] r_load_cnt, r_store_cnt;

  // Completion counters, bumped on the edge leaving RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else if (r_state == RESP) begin
      if (r_req.we) r_store_cnt <= r_store_cnt + 32'd1;
      else          r_load_cnt  <= r_load_cnt + 32'd1;
    end
  end

  assign load_cnt_o  = r_load_cnt;
  assign store_cnt_o = r_store_cnt;
`endif

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: one instance with WAIT_CYCLES=1 (sel 1), one with 0 (sel 0).
// Expected read data and completion edge are queued at issue and checked on mem_ready_o.
module tb_riscv_dmem_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] rd;
    int unsigned edge_no;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst1, rst0;
  int unsigned edge_cnt = 0;
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned n_ld1 = 0, n_st1 = 0, n_ld0 = 0, n_st0 = 0;

  logic [31:0] mdl1 [1024];
  logic [31:0] mdl0 [1024];
  logic [31:0] last1 = 32'h0, last0 = 32'h0;
  exp_t        q1[$], q0[$];

  riscv_dmem_ctrl_if if1 ();
  riscv_dmem_ctrl_if if0 ();

`ifdef RISCV_DMEM_STATS_EN
  logic [31:0] ld_cnt1, st_cnt1, ld_cnt0, st_cnt0;
`endif

  riscv_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk_i (clk_i),
    .rst_i (rst1),
    .bus   (if1.slave)
`ifdef RISCV_DMEM_STATS_EN
    ,
    .load_cnt_o  (ld_cnt1),
    .store_cnt_o (st_cnt1)
`endif
  );

  riscv_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i (clk_i),
    .rst_i (rst0),
    .bus   (if0.slave)
`ifdef RISCV_DMEM_STATS_EN
    ,
    .load_cnt_o  (ld_cnt0),
    .store_cnt_o (st_cnt0)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 1) begin
      if1.mem_req_i = req; if1.mem_we_i = we; if1.mem_be_i = be;
      if1.mem_addr_i = addr; if1.mem_wd_i = wd;
    end else begin
      if0.mem_req_i = req; if0.mem_we_i = we; if0.mem_be_i = be;
      if0.mem_addr_i = addr; if0.mem_wd_i = wd;
    end
  endtask

  // Issue one access, update the reference memory and queue the expected response
  task automatic issue(input int sel, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic [9:0]  idx;
    logic [31:0] w;
    idx = addr[11:2];
    @(negedge clk_i);
    e.we      = we;
    e.edge_no = edge_cnt + 1 + ((sel == 1) ? 1 : 0);
    w = (sel == 1) ? mdl1[idx] : mdl0[idx];
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      if (sel == 1) begin mdl1[idx] = w; e.rd = last1; n_st1++; end
      else          begin mdl0[idx] = w; e.rd = last0; n_st0++; end
    end else begin
      e.rd = w;
      if (sel == 1) begin last1 = w; n_ld1++; end
      else          begin last0 = w; n_ld0++; end
    end
    if (sel == 1) q1.push_back(e); else q0.push_back(e);
    drive(sel, 1'b1, we, be, addr, wd);
    @(posedge clk_i);
    #1;
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Bounded wait for the outstanding response, then confirm the pulse has ended
  task automatic wait_done(input int sel);
    int unsigned sz;
    for (int i = 0; i < 32; i++) begin
      sz = (sel == 1) ? q1.size() : q0.size();
      if (sz == 0) break;
      @(negedge clk_i);
      #1;
    end
    sz = (sel == 1) ? q1.size() : q0.size();
    check_eq("drain", 32'(sz), 32'h0);
    @(negedge clk_i);
    check_eq("ready_low_after", (sel == 1) ? 32'(if1.mem_ready_o) : 32'(if0.mem_ready_o), 32'h0);
  endtask

  // Response monitors
  always @(negedge clk_i) begin
    exp_t e;
    if (if1.mem_ready_o === 1'b1) begin
      if (q1.size() == 0) check_eq("dut1_spurious_ready", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        check_eq("dut1_ready_edge", 32'(edge_cnt), 32'(e.edge_no));
        check_eq(e.we ? "dut1_rd_after_store" : "dut1_load_data", if1.mem_rd_o, e.rd);
      end
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (if0.mem_ready_o === 1'b1) begin
      if (q0.size() == 0) check_eq("dut0_spurious_ready", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        check_eq("dut0_ready_edge", 32'(edge_cnt), 32'(e.edge_no));
        check_eq(e.we ? "dut0_rd_after_store" : "dut0_load_data", if0.mem_rd_o, e.rd);
      end
    end
  end

  initial begin
    logic [2:0]  ridx;
    logic [31:0] raddr;
    rst1 = 1'b1;
    rst0 = 1'b1;
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ready1", 32'(if1.mem_ready_o), 32'h0);
    check_eq("rst_rd1", if1.mem_rd_o, 32'h0);
    check_eq("rst_ready0", 32'(if0.mem_ready_o), 32'h0);
    check_eq("rst_rd0", if0.mem_rd_o, 32'h0);
    rst1 = 1'b0;
    rst0 = 1'b0;

    // Store then load
    issue(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); wait_done(1);
    issue(1, 1'b0, 4'h0, 32'h10, 32'h0);        wait_done(1);
    // Partial store; load ignores be
    issue(1, 1'b1, 4'hF, 32'h14, 32'h11223344); wait_done(1);
    issue(1, 1'b1, 4'h4, 32'h14, 32'hAAAAAAAA); wait_done(1);
    issue(1, 1'b0, 4'h1, 32'h14, 32'h0);        wait_done(1);
    // Store with no lanes enabled
    issue(1, 1'b1, 4'h0, 32'h10, 32'h55555555); wait_done(1);
    issue(1, 1'b0, 4'hF, 32'h10, 32'h0);        wait_done(1);
    // Address wrap
    issue(1, 1'b1, 4'hF, 32'h00001000, 32'h0BADC0DE); wait_done(1);
    issue(1, 1'b0, 4'hF, 32'h00000000, 32'h0);        wait_done(1);
    // Request during WAIT is ignored
    issue(1, 1'b1, 4'hF, 32'h18, 32'h77778888); wait_done(1);
    issue(1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h18, 32'hFFFFFFFF);
    @(posedge clk_i);
    #1;
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_done(1);
    issue(1, 1'b0, 4'hF, 32'h18, 32'h0);        wait_done(1);

    // Reset while a store sits in WAIT
    issue(1, 1'b1, 4'hF, 32'h20, 32'h12345678); wait_done(1);
    @(negedge clk_i);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    @(posedge clk_i);
    #1;
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check_eq("abort_ready_wait", 32'(if1.mem_ready_o), 32'h0);
    rst1 = 1'b1;
    @(negedge clk_i);
    check_eq("abort_ready_rst", 32'(if1.mem_ready_o), 32'h0);
    check_eq("abort_rd_zero", if1.mem_rd_o, 32'h0);
    rst1  = 1'b0;
    last1 = 32'h0;
    n_ld1 = 0;
    n_st1 = 0;
    repeat (2) @(negedge clk_i);
    issue(1, 1'b0, 4'hF, 32'h20, 32'h0);        wait_done(1);

    // Randomised traffic over a small, prefilled window with aliased upper bits
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom); wait_done(1);
    end
    for (int i = 0; i < 24; i++) begin
      ridx  = 3'($urandom_range(0, 7));
      raddr = 32'h200 + 32'(ridx) * 32'd4 + (32'($urandom_range(0, 3)) << 12);
      issue(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), raddr, $urandom);
      wait_done(1);
    end

    // Zero wait states
    issue(0, 1'b1, 4'hF, 32'h40, 32'hA5A5A5A5); wait_done(0);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0);        wait_done(0);
    issue(0, 1'b1, 4'h3, 32'h40, 32'h0000C3C3); wait_done(0);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0);        wait_done(0);
    issue(0, 1'b1, 4'hF, 32'h44, 32'h01020304); wait_done(0);
    issue(0, 1'b0, 4'h0, 32'h44, 32'h0);        wait_done(0);

    repeat (3) @(negedge clk_i);
`ifdef RISCV_DMEM_STATS_EN
    check_eq("load_cnt1", ld_cnt1, 32'(n_ld1));
    check_eq("store_cnt1", st_cnt1, 32'(n_st1));
    check_eq("load_cnt0", ld_cnt0, 32'(n_ld0));
    check_eq("store_cnt0", st_cnt0, 32'(n_st0));
`endif
    check_eq("q1_empty", 32'(q1.size()), 32'h0);
    check_eq("q0_empty", 32'(q0.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: data RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra wait states per access, range 0..15.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mem_req_i, input, 1 bit: access request from the load/store unit.
REQ-006 SHALL have port mem_we_i, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port mem_be_i, input, 4 bits: byte enables for stores; bit n selects byte lane n.
REQ-008 SHALL have port mem_addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-009 SHALL have port mem_wd_i, input, 32 bits: lane-replicated store data.
REQ-010 SHALL have port mem_rd_o, output, 32 bits: full read word.
REQ-011 SHALL have port mem_ready_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-013 SHALL, in IDLE with mem_req_i=1, capture we, be, word index and wd at the clock edge.
- Next state: WAIT if WAIT_CYCLES>0, else RESP.
- Wait counter loads WAIT_CYCLES-1.
REQ-014 SHALL, in WAIT, decrement the counter each cycle and move to RESP after the cycle in which the counter equals 0.
REQ-015 SHALL assert mem_ready_o only in RESP, for exactly one cycle, then return to IDLE.
- Request at edge N gives mem_ready_o high in cycle N+1+WAIT_CYCLES.
REQ-016 SHALL ignore mem_req_i in WAIT and RESP.
- Requests are never queued.
- A request held high into IDLE is accepted as a new access.
REQ-017 SHALL perform the RAM access on the edge that enters RESP.
- Store: write only the lanes whose captured be bit is 1.
- Load: register the full word into mem_rd_o.
REQ-018 SHALL hold mem_rd_o stable until the next load completes; stores SHALL NOT change mem_rd_o.
REQ-019 SHALL form the word index as captured addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-020 SHALL make a store with be=0000 complete normally (ready pulse) with no RAM change.
REQ-021 SHALL make a load return the full word regardless of be; lane extraction belongs to the load/store unit.

Reset
REQ-022 SHALL, on rst_i=1 at a clock edge, set state to IDLE, mem_ready_o to 0, mem_rd_o to 0 and the wait counter to 0.
REQ-023 SHALL abort any access in flight on reset: no RAM write, no ready pulse.
REQ-024 SHALL NOT reset RAM contents.

Configuration
REQ-025 SHALL, when macro RISCV_DMEM_STATS_EN is defined, add 32-bit outputs load_cnt_o and store_cnt_o.
- Each counter increments by 1 on every completed load/store respectively.
- Counters wrap from FFFFFFFF to 0 and reset to 0.
- Without the macro, these ports and counters SHALL NOT exist.

Structure
REQ-026 SHALL take the FSM state enum type and the WAIT_CYCLES width constant from shared package riscv_pkg.
REQ-027 SHALL place the byte-enabled RAM array in sub-module riscv_dmem_ram.
- One synchronous write port with 4-bit lane enables.
- One registered read port.

Verification
REQ-028 SHALL verify store then load, WAIT_CYCLES=1:
- Store addr 0x10, be 1111, wd 0xDEADBEEF at edge 0 -> ready in cycle 2.
- Load addr 0x10 at edge 3 -> ready in cycle 5 with mem_rd_o=0xDEADBEEF.
REQ-029 SHALL verify partial store:
- Word holds 0x11223344; store be 0100, wd 0xAAAAAAAA.
- Subsequent load returns 0x11AA3344.
REQ-030 SHALL verify WAIT_CYCLES=0: request at edge N -> ready high in cycle N+1 only, low in N+2.
REQ-031 SHALL verify wrap and busy behaviour, DEPTH_WORDS=1024:
- Store to 0x00001000 then load 0x00000000 returns the stored word.
- A mem_req_i pulse during WAIT is ignored.
REQ-032 SHALL verify reset in WAIT during a store:
- No RAM change and no ready pulse.
- State returns to IDLE; mem_rd_o=0.
REQ-033 SHALL verify, with RISCV_DMEM_STATS_EN: 3 loads and 2 stores -> load_cnt_o=3, store_cnt_o=2.
